jpeg_block_sequencer: RTL and testbench

JPEG_BLOCK_SEQUENCER -- requirements
Module: jpeg_block_sequencer

---
 rtl/jpeg_block_sequencer.sv | 167 ++++++++++++++++
 tb/tb_jpeg_block_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_block_sequencer.sv
// jpeg_block_sequencer
//   Feeds an image to a JPEG core as a series of 64-pixel blocks. For each
//   block it pulses core_rst for RST_CYCLES cycles. It then accepts 64 pixels
//   from the upstream valid/ready stream, passing each one to core_pixel one
//   cycle later. After the 64th pixel it idles for DRAIN_CYCLES cycles so the
//   core can flush, then starts the next block. A one-cycle done pulse marks
//   the end of the image.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   start, num_blocks     begin an image of num_blocks blocks (sampled in IDLE)
//   s_valid, s_pixel      upstream pixel stream
//   s_ready               high only while a block is being fed
//   core_pixel            registered pixel to the core
//   core_rst              per-block core reset pulse
//   core_data_valid       core output tag (00 none, 01 Y, 10 Cb, 11 Cr)
//   busy, done            activity flag, one-cycle image-end pulse
//   blk_idx               index of the block being fed or drained
//   underrun              sticky: upstream stalled while a block was fed
//   y_words, cb_words,    saturating per-channel output word counters,
//   cr_words              present only when JPEG_SEQ_WORDCNT_EN is defined
//
// Build option: define JPEG_SEQ_WORDCNT_EN to include the word counters.
module jpeg_block_sequencer #(
  parameter int PIX_W        = 24,
  parameter int DRAIN_CYCLES = 40,
  parameter int RST_CYCLES   = 1,
  parameter int BLK_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BLK_W-1:0] num_blocks,
  input  logic             s_valid,
  input  logic [PIX_W-1:0] s_pixel,
  output logic             s_ready,
  output logic [PIX_W-1:0] core_pixel,
  output logic             core_rst,
  input  logic [1:0]       core_data_valid,
  output logic             busy,
  output logic             done,
  output logic [BLK_W-1:0] blk_idx,
`ifdef JPEG_SEQ_WORDCNT_EN
  output logic [15:0]      y_words,
  output logic [15:0]      cb_words,
  output logic [15:0]      cr_words,
`endif
  output logic             underrun
);

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam int RW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CRST  = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [RW-1:0]    r_rst_cnt;
  logic [5:0]       r_pix_cnt;
  logic [DW-1:0]    r_drain_cnt;
  logic [BLK_W-1:0] r_num_blocks;
  logic [BLK_W-1:0] r_blk_idx;
  logic [PIX_W-1:0] r_core_pixel;
  logic             r_underrun;
  logic             w_start_acc;
  logic             w_accept;

  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_next      = (num_blocks != '0) ? S_CRST : S_DONE;
        end
      end
      S_CRST: begin
        if (r_rst_cnt == RW'(RST_CYCLES - 1)) w_next = S_FEED;
      end
      S_FEED: begin
        w_accept = s_valid;
        if (s_valid && (r_pix_cnt == 6'd63)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain_cnt == DW'(DRAIN_CYCLES - 1))
          w_next = (r_blk_idx == r_num_blocks - BLK_W'(1)) ? S_DONE : S_CRST;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rst_cnt    <= '0;
      r_pix_cnt    <= '0;
      r_drain_cnt  <= '0;
      r_num_blocks <= '0;
      r_blk_idx    <= '0;
      r_core_pixel <= '0;
      r_underrun   <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Phase counters run only while their state persists, so each entry
      // into a state starts them from zero.
      r_rst_cnt   <= (r_state == S_CRST && w_next == S_CRST) ? r_rst_cnt + RW'(1) : '0;
      r_drain_cnt <= (r_state == S_DRAIN && w_next == S_DRAIN) ? r_drain_cnt + DW'(1) : '0;
      if (r_state == S_CRST)  r_pix_cnt <= '0;
      else if (w_accept)      r_pix_cnt <= r_pix_cnt + 6'd1;
      if (w_accept)           r_core_pixel <= s_pixel;
      if (r_state == S_FEED && !s_valid) r_underrun <= 1'b1;
      if (r_state == S_DRAIN && w_next == S_CRST) r_blk_idx <= r_blk_idx + BLK_W'(1);
      if (w_start_acc) begin
        r_num_blocks <= num_blocks;
        r_blk_idx    <= '0;
        r_underrun   <= 1'b0;
      end
    end
  end

  assign s_ready    = (r_state == S_FEED);
  assign core_rst   = (r_state == S_CRST);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign core_pixel = r_core_pixel;
  assign blk_idx    = r_blk_idx;
  assign underrun   = r_underrun;

`ifdef JPEG_SEQ_WORDCNT_EN
  logic [15:0] r_y_words, r_cb_words, r_cr_words;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counting continues in every state so core output that trails done is
  // still attributed to the image.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_y_words  <= '0;
      r_cb_words <= '0;
      r_cr_words <= '0;
    end else begin
      if (core_data_valid == 2'b01) r_y_words  <= sat_inc(r_y_words);
      if (core_data_valid == 2'b10) r_cb_words <= sat_inc(r_cb_words);
      if (core_data_valid == 2'b11) r_cr_words <= sat_inc(r_cr_words);
    end
  end

  assign y_words  = r_y_words;
  assign cb_words = r_cb_words;
  assign cr_words = r_cr_words;
`else
  logic w_unused_cdv;
  assign w_unused_cdv = ^core_data_valid;
`endif

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Testbench for jpeg_block_sequencer: directed and randomized image runs
// checked against a transaction-level expectation model. Word counter checks
// are included when JPEG_SEQ_WORDCNT_EN is defined.
module tb_jpeg_block_sequencer;
  localparam int PIX_W = 24;
  localparam int DRAIN = 40;
  localparam int RSTC  = 1;
  localparam int BLK_W = 16;

  logic             clk = 1'b0;
  logic             rst, start, s_valid, s_ready, core_rst, busy, done, underrun;
  logic [BLK_W-1:0] num_blocks, blk_idx;
  logic [PIX_W-1:0] s_pixel, core_pixel;
  logic [1:0]       core_data_valid;
`ifdef JPEG_SEQ_WORDCNT_EN
  logic [15:0]      y_words, cb_words, cr_words;
`endif

  int checks   = 0;
  int failures = 0;
  logic [PIX_W-1:0] exp_pix;

  always #5 clk = ~clk;

  jpeg_block_sequencer #(
    .PIX_W(PIX_W), .DRAIN_CYCLES(DRAIN), .RST_CYCLES(RSTC), .BLK_W(BLK_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks),
    .s_valid(s_valid), .s_pixel(s_pixel), .s_ready(s_ready),
    .core_pixel(core_pixel), .core_rst(core_rst),
    .core_data_valid(core_data_valid), .busy(busy), .done(done),
    .blk_idx(blk_idx),
`ifdef JPEG_SEQ_WORDCNT_EN
    .y_words(y_words), .cb_words(cb_words), .cr_words(cr_words),
`endif
    .underrun(underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"},    32'(s_ready),    0);
    chk({tag, "_core_pixel"}, 32'(core_pixel), 0);
    chk({tag, "_core_rst"},   32'(core_rst),   0);
    chk({tag, "_busy"},       32'(busy),       0);
    chk({tag, "_done"},       32'(done),       0);
    chk({tag, "_blk_idx"},    32'(blk_idx),    0);
    chk({tag, "_underrun"},   32'(underrun),   0);
  endtask

  // Runs one image. Expectations: each block contributes one core_rst pulse,
  // exactly 64 accepted pixels, and the next block (or done) follows the last
  // accept of a block by DRAIN+1 cycles. pstall = percent chance of s_valid low
  // in FEED; drop_at/drop_len force a stall burst at a pixel position;
  // abort_blk >= 0 asserts rst at pixel 30 of that block.
  task automatic run_image(input int nb, input int pstall, input int drop_at,
                           input int drop_len, input int abort_blk);
    int cyc, exp_crst, last_acc, accepts, pulses, rst_hi, dones, pix_in_blk;
    int drop_left, budget;
    bit stalled, prev_rst, acc, got_done;
    logic [PIX_W-1:0] px;
    cyc = 0; exp_crst = 1; last_acc = 0; accepts = 0; pulses = 0; rst_hi = 0;
    dones = 0; pix_in_blk = 0; drop_left = drop_len; stalled = 0;
    prev_rst = 0; got_done = 0; px = '0;
    budget = nb * 400 + 20;
    start = 1'b1; num_blocks = BLK_W'(nb); s_valid = 1'b0;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc <= budget) begin
      chk("core_pixel", 32'(core_pixel), 32'(exp_pix));
      chk("busy_active", 32'(busy), 1);
      if (core_rst) begin
        rst_hi++;
        chk("s_ready_in_crst", 32'(s_ready), 0);
        if (!prev_rst) begin
          chk("crst_cycle", cyc, exp_crst);
          chk("blk_idx_at_crst", 32'(blk_idx), pulses);
          pulses++;
        end
      end
      prev_rst = core_rst;
      if (done) begin
        got_done = 1;
        dones++;
        chk("done_cycle", cyc, last_acc + DRAIN + 1);
        chk("blk_idx_final", 32'(blk_idx), nb - 1);
        chk("underrun_flag", 32'(underrun), 32'(stalled));
        if (pstall == 0 && drop_len == 0)
          chk("done_cycle_abs", cyc, 1 + nb * (RSTC + 64 + DRAIN));
        break;
      end
      acc = 0;
      s_pixel = PIX_W'($urandom);
      if (abort_blk >= 0 && s_ready && pulses - 1 == abort_blk && pix_in_blk == 30) begin
        rst = 1'b1; s_valid = 1'b0; start = 1'b0;
        step();
        check_reset_vals("abort");
        exp_pix = '0;
        rst = 1'b0;
        repeat (5) begin
          step();
          chk("no_done_after_abort", 32'(done), 0);
        end
        return;
      end
      if (s_ready) begin
        if (drop_at >= 0 && pix_in_blk == drop_at && drop_left > 0) begin
          s_valid = 1'b0;
          drop_left--;
        end else begin
          s_valid = ($urandom_range(99) >= pstall);
        end
        if (!s_valid) stalled = 1;
        else begin
          acc = 1; px = s_pixel; accepts++; pix_in_blk++;
          if (pix_in_blk == 64) begin
            last_acc = cyc; exp_crst = cyc + DRAIN + 1; pix_in_blk = 0;
          end
        end
      end else begin
        // Traffic outside FEED, including a start while busy, must be ignored.
        s_valid    = 1'($urandom_range(1));
        start      = 1'($urandom_range(1));
        num_blocks = BLK_W'($urandom_range(5));
      end
      step();
      cyc++;
      if (acc) exp_pix = px;
    end
    start = 1'b0; s_valid = 1'b0;
    chk("done_seen", 32'(got_done), 1);
    chk("accept_count", accepts, 64 * nb);
    chk("crst_pulses", pulses, nb);
    chk("crst_high_cycles", rst_hi, nb * RSTC);
    chk("done_count", dones, 1);
    step();
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_after_done", 32'(busy), 0);
    chk("core_pixel_after", 32'(core_pixel), 32'(exp_pix));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_blocks = '0; s_valid = 1'b0; s_pixel = '0;
    core_data_valid = 2'b00; exp_pix = '0;
    repeat (3) step();
    check_reset_vals("reset");
    rst = 1'b0;
    step();
    check_reset_vals("idle");

    // Start ignored attribute: a start issued during reset must not begin.
    rst = 1'b1; start = 1'b1; num_blocks = 16'd2;
    step();
    chk("rst_over_start_busy", 32'(busy), 0);
    rst = 1'b0; start = 1'b0;
    step();

    run_image(1, 0, -1, 0, -1);
    run_image(3, 0, -1, 0, -1);
    run_image(1, 0, 20, 5, -1);
    chk("underrun_sticky_idle", 32'(underrun), 1);

    // Empty image: done next cycle, no core reset, no ready.
    start = 1'b1; num_blocks = '0;
    step();
    start = 1'b0;
    chk("nb0_done", 32'(done), 1);
    chk("nb0_core_rst", 32'(core_rst), 0);
    chk("nb0_s_ready", 32'(s_ready), 0);
    chk("nb0_underrun_cleared", 32'(underrun), 0);
    step();
    chk("nb0_done_gone", 32'(done), 0);
    chk("nb0_idle", 32'(busy), 0);

    for (int i = 0; i < 3; i++) run_image(int'($urandom_range(3, 1)), 30, -1, 0, -1);

    run_image(3, 10, -1, 0, 1);
    run_image(2, 0, -1, 0, -1);

`ifdef JPEG_SEQ_WORDCNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_pix = '0;
    repeat (10) begin core_data_valid = 2'b01; step(); end
    repeat (4)  begin core_data_valid = 2'b10; step(); end
    repeat (4)  begin core_data_valid = 2'b11; step(); end
    core_data_valid = 2'b00;
    step();
    chk("y_words", 32'(y_words), 10);
    chk("cb_words", 32'(cb_words), 4);
    chk("cr_words", 32'(cr_words), 4);
    start = 1'b1; num_blocks = '0;
    step();
    start = 1'b0;
    chk("y_words_cleared", 32'(y_words), 0);
    step();
    core_data_valid = 2'b01;
    repeat (70000) step();
    core_data_valid = 2'b00;
    step();
    chk("y_words_sat", 32'(y_words), 32'hFFFF);
    chk("cb_words_zero", 32'(cb_words), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
